// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the fetch queue
package fetch_pkg;

  typedef enum logic {
    FQ_FETCH = 1'b0,
    FQ_HALT  = 1'b1
  } fq_state_e;

  localparam int FQ_PC_WIDTH    = 32;
  localparam int FQ_IWIDTH      = 32;
  localparam int FQ_ENTRY_WIDTH = FQ_PC_WIDTH + FQ_IWIDTH;

  function automatic int fq_entry_width(input int pc_width, input int iwidth);
    return pc_width + iwidth;
  endfunction

endpackage

// File: rtl/fetch_queue_buf.sv
// rtl/fetch_queue_buf.sv - circular buffer with push/pop/clear and occupancy count
module fetch_queue_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != FULL);
  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide, so increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch queue between instruction memory and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                  IWIDTH   = FQ_IWIDTH,
  parameter int                  PC_WIDTH = FQ_PC_WIDTH,
  parameter int                  QDEPTH   = 4,
  parameter int                  PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  localparam int                 CWIDTH   = $clog2(QDEPTH) + 1
) (
  input  logic                fq_clk,
  input  logic                fq_rst,
  output logic                fq_o_syn,
  output logic [PC_WIDTH-1:0] fq_o_addr,
  input  logic                fq_i_ack,
  input  logic [IWIDTH-1:0]   fq_i_instr,
  input  logic                fq_i_last,
  output logic [IWIDTH-1:0]   fq_o_instr,
  output logic [PC_WIDTH-1:0] fq_o_pc,
  output logic                fq_o_ce,
  input  logic                fq_i_stall,
  input  logic                fq_change_pc,
  input  logic [PC_WIDTH-1:0] fq_alu_pc_value,
  input  logic                fq_i_flush,
  output logic                fq_o_flush,
  output logic [CWIDTH-1:0]   fq_o_count
);

  localparam int            EWIDTH = fq_entry_width(PC_WIDTH, IWIDTH);
  localparam logic [CWIDTH-1:0] FULL = CWIDTH'(QDEPTH);

  fq_state_e            state;
  logic [PC_WIDTH-1:0]  fetch_pc;
  logic [EWIDTH-1:0]    head_data;
  logic                 push;
  logic                 pop;
  logic                 clear;

  // Gated by reset so no request leaks out while the block is held in reset.
  assign fq_o_syn  = fq_rst && (state == FQ_FETCH) && (fq_o_count != FULL)
                     && !fq_change_pc && !fq_i_flush;
  assign fq_o_addr = fetch_pc;
  assign push      = fq_o_syn && fq_i_ack;
  assign pop       = fq_o_ce && !fq_i_stall;
  assign clear     = fq_change_pc || fq_i_flush;
  assign fq_o_ce   = (fq_o_count != '0);
  assign {fq_o_pc, fq_o_instr} = head_data;

  fetch_queue_buf #(
    .DEPTH (QDEPTH),
    .WIDTH (EWIDTH)
  ) u_buf (
    .clk       (fq_clk),
    .rst_n     (fq_rst),
    .push      (push),
    .push_data ({fetch_pc, fq_i_instr}),
    .pop       (pop),
    .clear     (clear),
    .head_data (head_data),
    .count     (fq_o_count)
  );

  always_ff @(posedge fq_clk or negedge fq_rst) begin
    if (!fq_rst) begin
      state      <= FQ_FETCH;
      fetch_pc   <= RESET_PC;
      fq_o_flush <= 1'b0;
    end else begin
      fq_o_flush <= clear;
      if (fq_change_pc) begin
        fetch_pc <= fq_alu_pc_value;
        state    <= FQ_FETCH;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(PC_STEP);
        if (fq_i_last) state <= FQ_HALT;
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-entry fetch stage. The block decouples instruction-memory fetches from decode using a QDEPTH-entry prefetch queue of {pc, instr} pairs. It drives the syn/ack handshake toward instruction memory and holds the fetch PC. It handles PC redirect, flush, downstream stall and end-of-program (last) stop. It sits between the instruction memory/transmitter and the decode stage.

## Interface
- IWIDTH, 32, instruction width
- PC_WIDTH, 32, PC and memory address width
- QDEPTH, 4, queue entries; power of two, minimum 2
- PC_STEP, 4, fetch PC increment per accepted instruction
- RESET_PC, 0, fetch PC after reset
- CWIDTH, $clog2(QDEPTH)+1, occupancy count width (derived, not overridden)

Ports:
- fq_clk  in  1  clock, all state on rising edge
- fq_rst  in  1  reset; asynchronous, active-low
- fq_o_syn  out  1  fetch request to memory
- fq_o_addr  out  PC_WIDTH  request address (= fetch PC)
- fq_i_ack  in  1  memory accepted request; fq_i_instr valid this cycle
- fq_i_instr  in  IWIDTH  fetched instruction
- fq_i_last  in  1  qualifies ack: this is the final program instruction
- fq_o_instr  out  IWIDTH  head instruction to decode
- fq_o_pc  out  PC_WIDTH  PC of head instruction
- fq_o_ce  out  1  head valid
- fq_i_stall  in  1  decode cannot accept; head held
- fq_change_pc  in  1  redirect request
- fq_alu_pc_value  in  PC_WIDTH  redirect target
- fq_i_flush  in  1  flush queue, keep fetch PC
- fq_o_flush  out  1  one-cycle registered flush indication to downstream
- fq_o_count  out  CWIDTH  queue occupancy

## Operation
- FSM has two states. FETCH: requests allowed. HALT: entered on ack with fq_i_last; no requests until redirect.
- fq_o_syn = (state==FETCH) && (count < QDEPTH) && !fq_change_pc && !fq_i_flush. At most one request is outstanding. fq_o_addr is stable while syn is high.
- Ack while syn is high pushes {fetch_pc, fq_i_instr} at the tail; fetch_pc += PC_STEP (modulo 2^PC_WIDTH, wraps).
- Ack while syn is low is ignored.
- Pop occurs when fq_o_ce && !fq_i_stall. Head outputs are read from storage (show-ahead) and need no extra cycle.
- Push and pop in the same cycle leave count unchanged; this is legal at count==QDEPTH only as pop (no push possible).
- fq_change_pc (priority over everything):
  - queue emptied
  - any same-cycle ack discarded
  - fetch_pc <= fq_alu_pc_value
  - state <= FETCH
  - fq_o_flush=1 next cycle
- fq_i_flush without redirect: queue emptied, same-cycle ack discarded, fetch_pc unchanged, state unchanged, fq_o_flush=1 next cycle.
- Deasserting syn abandons a pending un-acked request; memory treats syn as a level request.
- fq_o_ce = count != 0.

## Timing
- Reset values: fetch_pc=RESET_PC, state=FETCH, count=0, read/write pointers 0, fq_o_ce=0, fq_o_flush=0, fq_o_instr=0, fq_o_pc=0, fq_o_syn=0 while reset is asserted.
- First syn is in the first cycle after reset release, with addr=RESET_PC.
- Latency from ack to fq_o_ce: 1 cycle, with an empty queue.
- Throughput is one instruction per cycle with zero-wait ack and no stall.
- Redirect asserted in cycle N: fq_o_ce=0 and syn=0 in N+1; syn with new addr in N+1 only if no redirect/flush then (flush inputs gate syn combinationally in cycle N itself).
- Reset mid-request: all state cleared immediately; outstanding request is dropped.

## Structure
- Package fetch_pkg holds the FSM state encoding (FQ_FETCH, FQ_HALT) and the entry-width localparam (PC_WIDTH+IWIDTH).
- One sub-module, fetch_queue_buf: circular buffer with push/pop/clear, wrap-around pointers and count.
- FSM and PC logic live in fetch_queue.

## Test plan
- Reset, ack every cycle, no stall, QDEPTH=4 -> addrs 0,4,8,...; fq_o_pc/instr match memory in order; count stays ≤1.
- Hold stall high, ack every cycle -> count reaches 4, syn drops, addr holds 16. Release stall -> head drains 0,4,8,12 and syn resumes at 16.
- Redirect to 0x100 while count=3 and ack is high -> acked instruction discarded; fq_o_flush=1 for one cycle; ce=0; next syn addr 0x100.
- fq_i_flush with count=2, fetch_pc=0x20 -> queue empty; next request addr 0x20.
- Ack with last at addr 0x1C -> entry delivered; syn stays low; redirect to 0 resumes fetching at 0.
- Fetch_pc=0xFFFFFFFC acked -> next addr 0x0 (wrap). Reset asserted mid-stall -> all outputs at reset values in the same cycle.
